// File: rtl/fp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared FP32 types and constants: field view, rounding modes,
//             exception flags and the reciprocal unit's side-FIFO record.
//  Macro    : FP_RECIP_FLAGS_EN adds the flag field to the side record.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Field view of an IEEE-754 binary32 word
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Rounding modes carried alongside an operation
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } fp_rm_e;

  // Canonical quiet NaN
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Exception flags, packed as {NV,DZ,UF}
  typedef struct packed {
    logic nv;
    logic dz;
    logic uf;
  } fp_flags_t;

  // Per-operation record kept in acceptance order until retirement
  typedef struct packed {
    logic        special;
    logic [31:0] result;
`ifdef FP_RECIP_FLAGS_EN
    fp_flags_t   flags;
`endif
    logic        sign;
    logic [7:0]  exp;
  } recip_side_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fifo_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fifo_sync
//  Purpose  : Single-clock FIFO, show-ahead read port (head visible on
//             o_rd_data whenever !o_empty), asynchronous active-high reset.
//             A write becomes visible at the head on the following cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = i_wr_en && !o_full;
  assign w_do_rd = i_rd_en && !o_empty;

  // Pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule : fifo_sync
`default_nettype wire

// File: rtl/fp32_reciprocal_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp32_reciprocal_unit
//  Purpose  : FP32 reciprocal wrapper. Classifies operands, answers special
//             cases locally, issues normal mantissas to an external fixed-
//             latency reciprocal core and reassembles results in order.
//  Macro    : FP_RECIP_FLAGS_EN - when defined, out_flags {NV,DZ,UF} exists
//             and flags are tracked through the side FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_reciprocal_unit
  import fp_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CORE_LATENCY = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_rm,
  output logic        m_valid,
  output logic [23:0] m_mant,
  output logic [2:0]  m_rm,
  output logic        m_sign,
  input  logic        r_valid,
  input  logic [23:0] r_mant,
  input  logic [2:0]  r_rm,
  input  logic        r_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef FP_RECIP_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  localparam int                OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]  C_DEPTH = OCC_W'(DEPTH);
  localparam int                SIDE_W  = $bits(recip_side_t);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  fp32_t              w_op;
  logic               w_accept;
  logic               w_consume;
  logic               w_is_normal;
  logic               w_frac_zero;
  recip_side_t        w_side;

  logic [OCC_W-1:0]   r_occ;

  logic               r_m_valid;
  logic [23:0]        r_m_mant;
  fp_rm_e             r_m_rm;
  logic               r_m_sign;

  logic [SIDE_W-1:0]  w_head_bits;
  recip_side_t        w_head;
  logic               w_side_empty;
  logic               w_side_full;
  logic [23:0]        w_res_mant;
  logic               w_res_empty;
  logic               w_res_full;

  logic               w_out_free;
  logic               w_retire;
  logic [31:0]        w_res_data;

  logic               r_out_valid;
  logic [31:0]        r_out_data;
`ifdef FP_RECIP_FLAGS_EN
  fp_flags_t          w_res_flags;
  fp_flags_t          r_out_flags;
`endif

  // Returned rm/sign and the always-01 top mantissa bits carry no information
  // here; the core latency only matters to whoever builds the core.
  logic               w_unused_sig;
  assign w_unused_sig = ^{r_rm, r_sign, w_res_mant[23:22], w_side_full,
                          w_res_full, (CORE_LATENCY > 0)};

  // --------------------------------------------------------------------------
  // Input handshake and occupancy
  // --------------------------------------------------------------------------
  assign w_op      = in_data;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  // Occupancy covers everything from acceptance until the output handshake,
  // so the side and result FIFOs can never overflow.
  assign in_ready  = !rst && (r_occ < C_DEPTH);

  // Track operations accepted but not yet consumed at the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (w_accept && !w_consume) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_accept && w_consume) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Operand classification: specials are fully resolved here
  // --------------------------------------------------------------------------
  assign w_frac_zero = (w_op.frac == 23'd0);

  // Build the side record and decide whether the core is needed
  always_comb begin
    w_side      = '0;
    w_side.sign = w_op.sign;
    w_side.exp  = w_op.exp;
    w_is_normal = 1'b0;
    if (w_op.exp == 8'hFF) begin
      w_side.special = 1'b1;
      if (!w_frac_zero) begin
        w_side.result = FP32_QNAN;
`ifdef FP_RECIP_FLAGS_EN
        w_side.flags.nv = ~w_op.frac[22];
`endif
      end else begin
        w_side.result = {w_op.sign, 31'd0};
      end
    end else if (w_op.exp == 8'h00) begin
      // Zero and denormal inputs both divide by zero after flushing
      w_side.special = 1'b1;
      w_side.result  = {w_op.sign, 8'hFF, 23'd0};
`ifdef FP_RECIP_FLAGS_EN
      w_side.flags.dz = 1'b1;
`endif
    end else if (w_frac_zero && (w_op.exp != 8'hFE)) begin
      // Exact power of two
      w_side.special = 1'b1;
      w_side.result  = {w_op.sign, 8'hFE - w_op.exp, 23'd0};
    end else if (w_frac_zero) begin
      // 1/2^127 is below the normal range
      w_side.special = 1'b1;
      w_side.result  = {w_op.sign, 31'd0};
`ifdef FP_RECIP_FLAGS_EN
      w_side.flags.uf = 1'b1;
`endif
    end else begin
      w_is_normal = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Core issue: one-cycle pulse in the cycle after a normal is accepted
  // --------------------------------------------------------------------------
  // Register the mantissa/rm/sign presented to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_mant  <= '0;
      r_m_rm    <= RNE;
      r_m_sign  <= 1'b0;
    end else begin
      r_m_valid <= w_accept && w_is_normal;
      if (w_accept && w_is_normal) begin
        r_m_mant <= {1'b1, w_op.frac};
        r_m_rm   <= fp_rm_e'(in_rm);
        r_m_sign <= w_op.sign;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_mant  = r_m_mant;
  assign m_rm    = r_m_rm;
  assign m_sign  = r_m_sign;

  // --------------------------------------------------------------------------
  // Ordering FIFOs
  // --------------------------------------------------------------------------
  fifo_sync #(
    .WIDTH (SIDE_W),
    .DEPTH (DEPTH)
  ) u_side_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_accept),
    .i_wr_data (w_side),
    .i_rd_en   (w_retire),
    .o_rd_data (w_head_bits),
    .o_empty   (w_side_empty),
    .o_full    (w_side_full)
  );

  assign w_head = w_head_bits;

  // The core cannot be stalled, so every returned mantissa is captured
  fifo_sync #(
    .WIDTH (24),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_valid),
    .i_wr_data (r_mant),
    .i_rd_en   (w_retire && !w_head.special),
    .o_rd_data (w_res_mant),
    .o_empty   (w_res_empty),
    .o_full    (w_res_full)
  );

  // --------------------------------------------------------------------------
  // Retirement and result assembly
  // --------------------------------------------------------------------------
  assign w_out_free = !r_out_valid || out_ready;
  assign w_retire   = w_out_free && !w_side_empty &&
                      (w_head.special || !w_res_empty);

  // Select the stored special result or rebuild a normal one from the core
  always_comb begin
    w_res_data = '0;
`ifdef FP_RECIP_FLAGS_EN
    w_res_flags = '0;
`endif
    if (w_head.special) begin
      w_res_data = w_head.result;
`ifdef FP_RECIP_FLAGS_EN
      w_res_flags = w_head.flags;
`endif
    end else if (w_head.exp >= 8'd253) begin
      // Result exponent would be zero or negative: flush to signed zero
      w_res_data = {w_head.sign, 31'd0};
`ifdef FP_RECIP_FLAGS_EN
      w_res_flags.uf = 1'b1;
`endif
    end else begin
      // Core result lies in (0.5,1): one exponent step down, bit 22 is the
      // hidden one and the remaining bits shift up by one.
      w_res_data = {w_head.sign, 8'd253 - w_head.exp, w_res_mant[21:0], 1'b0};
    end
  end

  // Output register: load on retirement, drop when consumed, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef FP_RECIP_FLAGS_EN
      r_out_flags <= '0;
`endif
    end else if (w_retire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res_data;
`ifdef FP_RECIP_FLAGS_EN
      r_out_flags <= w_res_flags;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`ifdef FP_RECIP_FLAGS_EN
  assign out_flags = r_out_flags;
`endif

endmodule : fp32_reciprocal_unit
`default_nettype wire

// File: tb/tb_fp32_reciprocal_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_reciprocal_unit
//  Purpose  : Directed, table-driven bench for fp32_reciprocal_unit with a
//             behavioural fixed-latency mantissa reciprocal core.
//  Macro    : FP_RECIP_FLAGS_EN enables flag checking.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_reciprocal_unit;
  import fp_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 15;
  localparam int NVEC  = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [2:0]  in_rm = '0;
  logic        m_valid;
  logic [23:0] m_mant;
  logic [2:0]  m_rm;
  logic        m_sign;
  logic        r_valid;
  logic [23:0] r_mant;
  logic [2:0]  r_rm;
  logic        r_sign;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
`ifdef FP_RECIP_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp32_reciprocal_unit #(
    .DEPTH        (DEPTH),
    .CORE_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rm     (in_rm),
    .m_valid   (m_valid),
    .m_mant    (m_mant),
    .m_rm      (m_rm),
    .m_sign    (m_sign),
    .r_valid   (r_valid),
    .r_mant    (r_mant),
    .r_rm      (r_rm),
    .r_sign    (r_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP_RECIP_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  // Truncated Q1.23 reciprocal: floor(2^46 / m)
  function automatic logic [23:0] recip_q(input logic [23:0] m);
    logic [47:0] num;
    num = 48'h1 << 46;
    if (m == 24'd0) return 24'd0;
    return 24'(num / {24'd0, m});
  endfunction

  // Behavioural core: fixed LAT-cycle pipeline, shares reset
  logic [LAT-1:0] pv;
  logic [23:0]    pm [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pm[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], m_valid};
      pm[0] <= recip_q(m_mant);
      for (int i = 1; i < LAT; i++) pm[i] <= pm[i-1];
    end
  end
  assign r_valid = pv[LAT-1];
  assign r_mant  = pm[LAT-1];
  assign r_rm    = 3'd0;
  assign r_sign  = 1'b0;

  // Issue monitor
  int          mv_cnt = 0;
  logic [23:0] mv_mant = '0;
  logic [2:0]  mv_rm = '0;
  logic        mv_sign = 1'b0;
  always @(posedge clk) begin
    if (m_valid) begin
      mv_cnt  <= mv_cnt + 1;
      mv_mant <= m_mant;
      mv_rm   <= m_rm;
      mv_sign <= m_sign;
    end
  end

  typedef struct {
    logic [31:0] din;
    logic [2:0]  rm;
    logic [31:0] dout;
    logic [2:0]  flags;   // {NV,DZ,UF}
    bit          normal;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one operand with out_ready=1, wait for its result and check it
  task automatic run_vec(input vec_t v, input string tag);
    int mv0;
    int lat;
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    mv0      = mv_cnt;
    in_valid = 1'b1;
    in_data  = v.din;
    in_rm    = v.rm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " data"}, out_data, v.dout);
`ifdef FP_RECIP_FLAGS_EN
    check({tag, " flags"}, {29'd0, out_flags}, {29'd0, v.flags});
`endif
    check({tag, " latency"}, lat, v.normal ? LAT + 3 : 2);
    check({tag, " issues"}, mv_cnt - mv0, v.normal ? 1 : 0);
    if (v.normal) begin
      check({tag, " m_mant"}, {8'd0, mv_mant}, {8'd0, 1'b1, v.din[22:0]});
      check({tag, " m_rm"}, {29'd0, mv_rm}, {29'd0, v.rm});
      check({tag, " m_sign"}, {31'd0, mv_sign}, {31'd0, v.din[31]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int got;
    int cyc;
    int nout;
    logic [31:0] exp_seq [3];

    vecs[0]  = '{32'h4000_0000, RNE, 32'h3F00_0000, 3'b000, 1'b0};
    vecs[1]  = '{32'h3F80_0000, RNE, 32'h3F80_0000, 3'b000, 1'b0};
    vecs[2]  = '{32'h3F00_0000, RNE, 32'h4000_0000, 3'b000, 1'b0};
    vecs[3]  = '{32'h0000_0000, RNE, 32'h7F80_0000, 3'b010, 1'b0};
    vecs[4]  = '{32'h8000_0000, RNE, 32'hFF80_0000, 3'b010, 1'b0};
    vecs[5]  = '{32'h0000_0001, RNE, 32'h7F80_0000, 3'b010, 1'b0};
    vecs[6]  = '{32'h7F80_0001, RNE, 32'h7FC0_0000, 3'b100, 1'b0};
    vecs[7]  = '{32'hFFC0_0000, RNE, 32'h7FC0_0000, 3'b000, 1'b0};
    vecs[8]  = '{32'h7F80_0000, RNE, 32'h0000_0000, 3'b000, 1'b0};
    vecs[9]  = '{32'hFF80_0000, RNE, 32'h8000_0000, 3'b000, 1'b0};
    vecs[10] = '{32'h0080_0000, RNE, 32'h7E80_0000, 3'b000, 1'b0};
    vecs[11] = '{32'hFF00_0000, RNE, 32'h8000_0000, 3'b001, 1'b0};
    vecs[12] = '{32'h4040_0000, RNE, 32'h3EAA_AAAA, 3'b000, 1'b1};
    vecs[13] = '{32'h3FC0_0000, RTZ, 32'h3F2A_AAAA, 3'b000, 1'b1};
    vecs[14] = '{32'hC0A0_0000, RMM, 32'hBE4C_CCCC, 3'b000, 1'b1};
    vecs[15] = '{32'h7E80_0001, RNE, 32'h0000_0000, 3'b001, 1'b1};
    vecs[16] = '{32'h7E00_0001, RUP, 32'h00FF_FFFE, 3'b000, 1'b1};
    vecs[17] = '{32'h7F00_0001, RDN, 32'h0000_0000, 3'b001, 1'b1};

    // Reset state
    @(posedge clk);
    #2;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst m_valid", {31'd0, m_valid}, 32'd0);
    check("rst m_mant", {8'd0, m_mant}, 32'd0);
`ifdef FP_RECIP_FLAGS_EN
    check("rst out_flags", {29'd0, out_flags}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back mix held at the output, then drained in order
    exp_seq[0] = 32'h3EAA_AAAA;
    exp_seq[1] = 32'h7F80_0000;
    exp_seq[2] = 32'h3EAA_AAAA;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rm     = RNE;
    in_data   = 32'h4040_0000;
    @(negedge clk);
    in_data   = 32'h0000_0000;
    @(negedge clk);
    in_data   = 32'h4040_0000;
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (25) @(negedge clk);
    check("hold valid@25", {31'd0, out_valid}, 32'd1);
    check("hold data@25", out_data, 32'h3EAA_AAAA);
    repeat (15) @(negedge clk);
    check("hold data@40", out_data, 32'h3EAA_AAAA);
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 100) begin
      if (out_valid) begin
        check($sformatf("order out%0d", got), out_data, exp_seq[got]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("order count", got, 3);
    check("order drained", {31'd0, out_valid}, 32'd0);

    // Fill to DEPTH with the output stalled
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h4040_0000;
    acc = 0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      if (in_ready) acc++;
      @(negedge clk);
    end
    check("full accepts", acc, DEPTH);
    check("full in_ready", {31'd0, in_ready}, 32'd0);
    check("full out_data", out_data, 32'h3EAA_AAAA);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("one freed in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the stream
    rst = 1'b1;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst m_valid", {31'd0, m_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst release in_ready", {31'd0, in_ready}, 32'd1);
    nout = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    check("no stale outputs", nout, 0);
    run_vec(vecs[12], "post-midrst");
    run_vec(vecs[3], "post-midrst special");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fp32_reciprocal_unit
`default_nettype wire

// File: doc/fp32_reciprocal_unit.md
FP32_RECIPROCAL_UNIT -- requirements
Module: fp32_reciprocal_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 16: max operations in flight, power of two, at least 4.
REQ-002 SHALL have parameter CORE_LATENCY, default 15: fixed m_valid-to-r_valid cycles of the attached mantissa reciprocal core.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- in_data  in  32  FP32 operand.
- in_rm  in  3  rounding mode.
- m_valid  out  1  issue to core.
- m_mant  out  24  Q1.23 mantissa {1,frac}.
- m_rm  out  3  rounding mode to core.
- m_sign  out  1  sign to core.
- r_valid  in  1  core result valid; cannot be stalled.
- r_mant  in  24  Q1.23 reciprocal, in (0.5,1).
- r_rm  in  3  returned rounding mode; unused.
- r_sign  in  1  returned sign; unused.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  32  FP32 reciprocal.
- out_flags  out  3  {NV,DZ,UF}; present only under the macro in REQ-017.

Function
REQ-004 SHALL set in_ready = (occupancy < DEPTH), where occupancy counts operations accepted but not yet retired at the output.
REQ-005 SHALL classify each accepted operand (e = exponent field, f = fraction field) as follows:
- NaN: output 0x7FC00000; NV set iff f[22]==0.
- ±Inf: output ±0.
- ±0 or e==0: denormals flush to zero; output ±Inf, DZ set.
- f==0 with e in 1..253: exact; output {s, 254-e, 0}.
- f==0 with e==254: output ±0, UF set.
- otherwise: normal.
REQ-006 SHALL, for a normal operand, assert m_valid for exactly one cycle in the cycle after acceptance, with m_mant={1,f}, m_rm=in_rm and m_sign=s; specials SHALL NOT be issued.
REQ-007 SHALL push one side entry per accepted operation into an in-order side FIFO: {special, special_result, flags, sign, exponent}.
REQ-008 SHALL capture every r_valid cycle's r_mant into a result FIFO of depth DEPTH; overflow is impossible by REQ-004.
REQ-009 SHALL form a normal result as: sign s, exponent 253-e, fraction {r_mant[21:0],1'b0}; no post-rounding is applied.
REQ-010 SHALL flush a normal result to ±0 with UF set when 253-e <= 0, i.e. e >= 253.
REQ-011 SHALL retire the side-FIFO head when the output register is empty or being consumed:
- special head: retires immediately.
- normal head: retires only when the result FIFO is non-empty, and pops both FIFOs.
REQ-012 SHALL deliver outputs strictly in acceptance order, regardless of the special/normal mix.
REQ-013 SHALL hold out_valid, out_data and out_flags stable while out_valid && !out_ready.
REQ-014 SHALL give a minimum latency, acceptance to out_valid, of 2 cycles for specials and CORE_LATENCY+3 cycles for normals.
REQ-015 SHALL allow acceptance and retirement in the same cycle at full occupancy: occupancy is unchanged, and in_ready stays 0 for that cycle.

Reset
REQ-016 SHALL, while rst is high, clear both FIFOs and occupancy, and drive out_valid=0, out_data=0, out_flags=0, m_valid=0, m_mant=0, m_rm=0, m_sign=0 and in_ready=0. After release, in_ready=1. Reset mid-operation discards all in-flight work. The core SHALL share rst.

Configuration
REQ-017 SHALL, with FP_RECIP_FLAGS_EN defined, compute and register out_flags per REQ-005/010. Without it, out_flags and the side-FIFO flag field SHALL be absent; out_data is identical in both builds.

Structure
REQ-018 SHALL take from shared package fp_pkg:
- fp32 field struct.
- rounding-mode enum: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4.
- FP32_QNAN constant 0x7FC00000.
- flag struct {nv,dz,uf}.
REQ-019 SHALL instantiate sub-module fifo_sync (parameterised width/depth, asynchronous reset) twice: side FIFO and result FIFO. The core is external, connected via the m_/r_ ports.

Verification
REQ-020 in 0x40000000 (2.0) -> out 0x3F000000, flags 0, no m_valid pulse.
REQ-021 in 0x00000000 -> 0x7F800000 DZ; in 0x80000000 -> 0xFF800000 DZ; in 0x7F800001 -> 0x7FC00000 NV; in 0xFF800000 -> 0x80000000.
REQ-022 in 0x40400000 (3.0) with core returning 0x555555 -> m_mant=0xC00000, out 0x3EAAAAAA, flags 0, latency CORE_LATENCY+3.
REQ-023 in 0x7E800001 (e=253) -> out 0x00000000, UF set.
REQ-024 3.0, 0.0, 3.0 back-to-back with out_ready=0 for 40 cycles, then 1 -> outputs 0x3EAAAAAA, 0x7F800000, 0x3EAAAAAA in that order, no loss.
REQ-025 out_ready=0, continuous in_valid -> exactly DEPTH accepts then in_ready=0; one output consumed -> in_ready=1 next cycle; rst pulse mid-stream -> out_valid=0 and no stale outputs afterwards.
